// File: rtl/cnn_result_tx_if.sv
// Result-word write port and UART byte handshake of the CNN result packet framer.
interface cnn_result_tx_if #(
  parameter int unsigned WORD_W = 16
) ();
  logic              wr_vld;
  logic [WORD_W-1:0] wr_data;
  logic              wr_rdy;
  logic              send;
  logic              busy;
  logic              pkt_done;
  logic              trmt;
  logic [7:0]        tx_data;
  logic              tx_done;

  // Master: classifier side plus the UART transmitter.
  modport master (
    output wr_vld, wr_data, send, tx_done,
    input  wr_rdy, busy, pkt_done, trmt, tx_data
  );

  // Slave: the framer itself.
  modport slave (
    input  wr_vld, wr_data, send, tx_done,
    output wr_rdy, busy, pkt_done, trmt, tx_data
  );
endinterface

// File: rtl/cnn_result_tx.sv
// Buffers CNN result words and frames them to the UART as [HDR][LEN][payload][CHK].
// Optional feature macro RESULT_TX_CHKSUM_EN: when undefined, no CHK byte is sent.
module cnn_result_tx #(
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned DEPTH    = 16,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  cnn_result_tx_if.slave bus
);

  localparam int unsigned BYTES = WORD_W / 8;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  // Each byte state covers its issue cycle (trmt_q high) and the wait for tx_done.
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LEN,
    S_DATA
`ifdef RESULT_TX_CHKSUM_EN
    , S_CHK
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     words_q, words_d;
  logic [BW-1:0]     bytes_q, bytes_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              trmt_q, trmt_d;
  logic              busy_q, busy_d;
  logic              pkt_done_q, pkt_done_d;
  logic              wr_rdy_q, wr_rdy_d;
`ifdef RESULT_TX_CHKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic              push_c;
  logic              pop_c;
  logic              adv_c;
  logic              start_c;
  logic [7:0]        len_c;
  logic [WORD_W-1:0] head_c;

  assign push_c  = bus.wr_vld & wr_rdy_q;
  // tx_done during the trmt cycle may still be high from the previous frame.
  assign adv_c   = bus.tx_done & ~trmt_q;
  assign start_c = bus.send & (count_q != '0);
  assign len_c   = 8'(words_q * BYTES);
  assign head_c  = mem_q[rd_ptr_q];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_c) state_d = S_HDR;
      S_HDR:  if (adv_c)   state_d = S_LEN;
      S_LEN:  if (adv_c)   state_d = S_DATA;
      S_DATA: begin
        if (adv_c && (bytes_q == '0) && (words_q == '0)) begin
`ifdef RESULT_TX_CHKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef RESULT_TX_CHKSUM_EN
      S_CHK:  if (adv_c)   state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
    if (clr) state_d = S_IDLE;
  end

  // Output and datapath logic
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    words_d    = words_q;
    bytes_d    = bytes_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;
    trmt_d     = 1'b0;
    pkt_done_d = 1'b0;
    pop_c      = 1'b0;
`ifdef RESULT_TX_CHKSUM_EN
    chk_d      = chk_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          trmt_d    = 1'b1;
          tx_data_d = HDR_BYTE;
          words_d   = count_q;
`ifdef RESULT_TX_CHKSUM_EN
          chk_d     = 8'h00;
`endif
        end
      end
      S_HDR: begin
        if (adv_c) begin
          trmt_d    = 1'b1;
          tx_data_d = len_c;
        end
      end
      S_LEN: begin
        if (adv_c) pop_c = 1'b1;
      end
      S_DATA: begin
        if (adv_c) begin
          if (bytes_q != '0) begin
            trmt_d    = 1'b1;
            tx_data_d = shift_q[WORD_W-1 -: 8];
            shift_d   = shift_q << 8;
            bytes_d   = bytes_q - BW'(1);
          end else if (words_q != '0) begin
            pop_c = 1'b1;
          end else begin
`ifdef RESULT_TX_CHKSUM_EN
            trmt_d    = 1'b1;
            tx_data_d = chk_q;
`else
            pkt_done_d = 1'b1;
`endif
          end
        end
      end
`ifdef RESULT_TX_CHKSUM_EN
      S_CHK: begin
        if (adv_c) pkt_done_d = 1'b1;
      end
`endif
      default: ;
    endcase

    // Start of a new word: pop it and send its top byte, keep the rest in the shifter.
    if (pop_c) begin
      trmt_d    = 1'b1;
      tx_data_d = head_c[WORD_W-1 -: 8];
      shift_d   = head_c << 8;
      bytes_d   = BW'(BYTES - 1);
      words_d   = words_q - CW'(1);
      rd_ptr_d  = rd_ptr_q + AW'(1);
    end

`ifdef RESULT_TX_CHKSUM_EN
    // LEN and payload bytes are summed as they are issued; HDR and CHK are not.
    if (trmt_d && (state_q != S_IDLE) && (state_d != S_CHK)) chk_d = chk_q + tx_data_d;
`endif

    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    count_d  = count_q + CW'(push_c) - CW'(pop_c);
    busy_d   = (state_d != S_IDLE);
    wr_rdy_d = (count_d != CW'(DEPTH));

    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      words_d    = '0;
      bytes_d    = '0;
      shift_d    = '0;
      tx_data_d  = 8'h00;
      trmt_d     = 1'b0;
      pkt_done_d = 1'b0;
      busy_d     = 1'b0;
      wr_rdy_d   = 1'b1;
`ifdef RESULT_TX_CHKSUM_EN
      chk_d      = 8'h00;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      words_q    <= '0;
      bytes_q    <= '0;
      shift_q    <= '0;
      tx_data_q  <= 8'h00;
      trmt_q     <= 1'b0;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
      wr_rdy_q   <= 1'b1;
`ifdef RESULT_TX_CHKSUM_EN
      chk_q      <= 8'h00;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      words_q    <= words_d;
      bytes_q    <= bytes_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
      trmt_q     <= trmt_d;
      busy_q     <= busy_d;
      pkt_done_q <= pkt_done_d;
      wr_rdy_q   <= wr_rdy_d;
`ifdef RESULT_TX_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  // Word storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.wr_rdy   = wr_rdy_q;
  assign bus.busy     = busy_q;
  assign bus.pkt_done = pkt_done_q;
  assign bus.trmt     = trmt_q;
  assign bus.tx_data  = tx_data_q;

endmodule
